switch_debounce: RTL

//  Front-end stage for the slide-switch bank. Synchronises the raw switches, debounces each one, and

---
 rtl/sw_pkg.sv | 23 ++
 rtl/debounce_bit.sv | 60 ++++++
 rtl/switch_debounce.sv | 57 +++++
 3 files changed

// File: rtl/sw_pkg.sv
// Shared definitions for the slide-switch front end and its downstream one-hot encoder.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: none; the switch path is a free-running level pipeline.
package sw_pkg;

  // Width of the switch bank.
  localparam int N_SW = 10;

  // Stable cycles needed before a switch level is accepted: 10 ms at 50 MHz.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

  // True when exactly one bit of vec is set. All-zero and multi-bit vectors are
  // not legal one-hot codes.
  function automatic logic onehot_chk(input logic [N_SW-1:0] vec);
    int unsigned ones;
    ones = 0;
    for (int i = 0; i < N_SW; i++) begin
      if (vec[i]) ones++;
    end
    return (ones == 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: 2-flop synchroniser, stability counter and clean level flop.
// Latency: a level held from edge 0 reaches q_clean at edge DEBOUNCE_CYCLES+1.
// Backpressure: none; samples every cycle.
// Ports: clk, rst_n (sync, active-low), d_async (raw pin), q_clean (registered
//        clean level), q_next (value q_clean takes on the next edge).
module debounce_bit
  import sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_async,
  output logic q_clean,
  output logic q_next
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clean_q, clean_d;

  always_comb begin
    s1_d    = d_async;
    s2_d    = s1_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    if (s2_q == clean_q) begin
      // Any agreement restarts the stability window, so short glitches are dropped.
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      // Counter tops out exactly at CNT_MAX and clears here, so it can never wrap.
      clean_d = s2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  assign q_clean = clean_q;
  assign q_next  = clean_d;

endmodule

// File: rtl/switch_debounce.sv
// Switch-bank front end: per-bit sync + debounce, plus one-hot flag and change pulse.
// Latency: raw level held from edge 0 appears on all outputs at edge DEBOUNCE_CYCLES+1.
// Backpressure: none; outputs are plain registered levels/pulses.
// Ports: clk, rst_n (sync, active-low), sw_raw[N_SW] (async pins), sw_clean[N_SW],
//        sw_onehot (sw_clean has exactly one bit set), sw_change (1-cycle pulse).
module switch_debounce
  import sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_clean,
  output logic            sw_onehot,
  output logic            sw_change
);

  logic [N_SW-1:0] clean_cur;
  logic [N_SW-1:0] clean_next;

  for (genvar g = 0; g < N_SW; g++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_async(sw_raw[g]),
      .q_clean(clean_cur[g]),
      .q_next (clean_next[g])
    );
  end

  // Flags are derived from clean_next so they land on the same edge as sw_clean.
  logic onehot_q, onehot_d;
  logic change_q, change_d;

  always_comb begin
    onehot_d = onehot_chk(clean_next);
    change_d = (clean_next != clean_cur);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      onehot_q <= 1'b0;
      change_q <= 1'b0;
    end else begin
      onehot_q <= onehot_d;
      change_q <= change_d;
    end
  end

  assign sw_clean  = clean_cur;
  assign sw_onehot = onehot_q;
  assign sw_change = change_q;

endmodule
